// File: rtl/uart_alu_pkg.sv
// Shared types and defaults for the UART-to-ALU frame interface.
package uart_alu_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned OP_W_DEF   = 6;
    localparam logic [7:0]  DELIM_DEF  = 8'd32;

    typedef enum logic [2:0] {
        S_A,
        S_OP,
        S_B,
        S_CALC,
        S_TX,
        S_WAIT
    } state_t;

    // Bytes per operand/result word.
    function automatic int unsigned nbytes(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/rise_det.sv
// Single-bit rising-edge detector; history register resets to RST_VAL so a
// level already high at reset release does not produce an event.
module rise_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise_c
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= din;
        end
    end

    assign rise_c = din & ~prev_q;

endmodule

// File: rtl/uart_alu_frame_if.sv
// Parses "A DELIM op B DELIM" byte frames into ALU operands and streams the
// DATA_W-bit ALU result back to the transmitter MSB byte first.
module uart_alu_frame_if
    import uart_alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF,
    parameter logic [7:0]  DELIM  = DELIM_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        d_in,
    input  logic              rx_done,
    input  logic              tx_done,
    input  logic [DATA_W-1:0] d_out_ALU,
    output logic [7:0]        d_out,
    output logic              tx_start,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [OP_W-1:0]   opcode,
    output logic              busy,
    output logic              err
);

    localparam int unsigned NBYTES = nbytes(DATA_W);
    localparam int unsigned CNT_W  = $clog2(NBYTES + 2);
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NBYTES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_d, b_d, res_q, res_d;
    logic [OP_W-1:0]   op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        d_out_d;
    logic              err_d, tx_start_d, busy_d;
    logic              rx_ev, tx_ev;

    rise_det #(.RST_VAL(1'b1)) u_rx_det (
        .clk    (clk),
        .reset  (reset),
        .din    (rx_done),
        .rise_c (rx_ev)
    );

    rise_det #(.RST_VAL(1'b1)) u_tx_det (
        .clk    (clk),
        .reset  (reset),
        .din    (tx_done),
        .rise_c (tx_ev)
    );

    // Field byte count saturates one past NBYTES; that is enough to flag overflow.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        a_d        = A;
        b_d        = B;
        op_d       = opcode;
        err_d      = err;
        cnt_d      = cnt_q;
        res_d      = res_q;
        idx_d      = idx_q;
        d_out_d    = d_out;
        tx_start_d = 1'b0;

        case (state_q)
            S_A: begin
                if (rx_ev) begin
                    // cnt_q == 0 marks the first byte of a new frame.
                    if (cnt_q == '0) begin
                        err_d = 1'b0;
                    end
                    if (d_in == DELIM) begin
                        if (cnt_q == '0) begin
                            a_d = '0;
                        end
                        cnt_d   = '0;
                        state_d = S_OP;
                    end else begin
                        a_d   = (cnt_q == '0) ? DATA_W'(d_in) : DATA_W'({A, d_in});
                        cnt_d = cnt_inc;
                        if (cnt_inc > CNT_FULL) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            S_OP: begin
                if (rx_ev) begin
                    op_d    = d_in[OP_W-1:0];
                    b_d     = '0;
                    cnt_d   = '0;
                    state_d = S_B;
                end
            end

            S_B: begin
                if (rx_ev) begin
                    if (d_in == DELIM) begin
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end else begin
                        b_d   = DATA_W'({B, d_in});
                        cnt_d = cnt_inc;
                        if (cnt_inc > CNT_FULL) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            // tx_start/d_out are registered, so they are launched on entry to S_TX.
            S_CALC: begin
                res_d      = d_out_ALU;
                idx_d      = '0;
                d_out_d    = d_out_ALU[DATA_W-1 -: 8];
                tx_start_d = 1'b1;
                state_d    = S_TX;
            end

            S_TX: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (tx_ev) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_A;
                    end else begin
                        res_d      = res_q << 8;
                        idx_d      = idx_q + IDX_W'(1);
                        d_out_d    = res_d[DATA_W-1 -: 8];
                        tx_start_d = 1'b1;
                        state_d    = S_TX;
                    end
                end
            end

            default: begin
                state_d = S_A;
            end
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_TX) || (state_d == S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_A;
            A        <= '0;
            B        <= '0;
            opcode   <= '0;
            err      <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            idx_q    <= '0;
            d_out    <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            A        <= a_d;
            B        <= b_d;
            opcode   <= op_d;
            err      <= err_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            idx_q    <= idx_d;
            d_out    <= d_out_d;
            tx_start <= tx_start_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_alu_frame_if.sv
// Randomized frame-level bench for uart_alu_frame_if with an adder as the ALU.
module tb_uart_alu_frame_if;

    localparam int unsigned NB = 4;
    localparam logic [7:0]  DL = 8'd32;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  d_in = 8'h00;
    logic        rx_done = 1'b0;
    logic        tx_done = 1'b0;
    logic [31:0] alu_res;
    logic [7:0]  d_out;
    logic        tx_start;
    logic [31:0] a_o, b_o;
    logic [5:0]  opcode;
    logic        busy, err;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_a = 0, exp_b = 0;
    logic [5:0]  exp_op = 0;
    logic        exp_err = 0;
    logic [7:0]  tx_seen[$];

    uart_alu_frame_if dut (
        .clk       (clk),
        .reset     (reset),
        .d_in      (d_in),
        .rx_done   (rx_done),
        .tx_done   (tx_done),
        .d_out_ALU (alu_res),
        .d_out     (d_out),
        .tx_start  (tx_start),
        .A         (a_o),
        .B         (b_o),
        .opcode    (opcode),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    assign alu_res = a_o + b_o;

    // Record every transmitted byte; a stretched pulse shows up as an extra entry.
    always @(posedge clk) begin
        if (tx_start) tx_seen.push_back(d_out);
    end

    // Operand value = last bytes received, MSB first, truncated to 32 bits.
    function automatic logic [31:0] field_val(input bq_t q);
        logic [31:0] v;
        v = 0;
        foreach (q[i]) v = (v << 8) | 32'(q[i]);
        return v;
    endfunction

    function automatic logic [7:0] rand_data();
        logic [7:0] v;
        do v = 8'($urandom_range(0, 255)); while (v == DL);
        return v;
    endfunction

    function automatic bq_t rand_field(input int len);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(rand_data());
        return q;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        d_in = b;
        rx_done = 1'b1;
        repeat (hold) @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input bq_t qa, input logic [7:0] opc, input bq_t qb,
                              input int hmin, input int hmax);
        tx_seen.delete();
        foreach (qa[i]) send_byte(qa[i], $urandom_range(hmin, hmax));
        send_byte(DL, $urandom_range(hmin, hmax));
        send_byte(opc, $urandom_range(hmin, hmax));
        foreach (qb[i]) send_byte(qb[i], $urandom_range(hmin, hmax));
        send_byte(DL, $urandom_range(hmin, hmax));
        exp_a   = field_val(qa);
        exp_b   = field_val(qb);
        exp_op  = opc[5:0];
        exp_err = (qa.size() > NB) || (qb.size() > NB);
        checks++; if (a_o !== exp_a) begin failures++; $display("FAIL frame_A: got %h expected %h", a_o, exp_a); end
        checks++; if (b_o !== exp_b) begin failures++; $display("FAIL frame_B: got %h expected %h", b_o, exp_b); end
        checks++; if (opcode !== exp_op) begin failures++; $display("FAIL frame_opcode: got %h expected %h", opcode, exp_op); end
        checks++; if (err !== exp_err) begin failures++; $display("FAIL frame_err: got %b expected %b", err, exp_err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL frame_busy: got %b expected 1", busy); end
    endtask

    // Acknowledge NB bytes and check each against the expected sum.
    task automatic run_tx(input bit inject);
        logic [31:0] res;
        logic [7:0]  eb;
        int waited;
        res = exp_a + exp_b;
        for (int k = 0; k < NB; k++) begin
            waited = 0;
            while (tx_seen.size() <= k && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            checks++;
            if (tx_seen.size() <= k) begin
                failures++;
                $display("FAIL tx_timeout: got %0d pulses expected %0d", tx_seen.size(), k + 1);
                return;
            end
            eb = 8'(res >> (8 * (NB - 1 - k)));
            checks++; if (tx_seen[k] !== eb) begin failures++; $display("FAIL tx_byte%0d: got %h expected %h", k, tx_seen[k], eb); end
            if (inject && k == 0) begin
                repeat (3) begin
                    @(negedge clk);
                    d_in = 8'($urandom_range(0, 255));
                    rx_done = 1'b1;
                    @(negedge clk);
                    rx_done = 1'b0;
                end
                @(negedge clk);
                checks++; if (a_o !== exp_a) begin failures++; $display("FAIL inject_A: got %h expected %h", a_o, exp_a); end
                checks++; if (b_o !== exp_b) begin failures++; $display("FAIL inject_B: got %h expected %h", b_o, exp_b); end
            end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL tx_busy%0d: got %b expected 1", k, busy); end
            @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            if (k == NB - 1) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_fall: got %b expected 0", busy); end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            tx_done = 1'b0;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        checks++; if (tx_seen.size() != NB) begin failures++; $display("FAIL tx_count: got %0d expected %0d", tx_seen.size(), NB); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({d_out, tx_start, a_o, b_o, opcode, busy, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got d_out=%h tx=%b A=%h B=%h op=%h busy=%b err=%b expected all 0",
                     d_out, tx_start, a_o, b_o, opcode, busy, err);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        bq_t qa, qb;
        qa = '{8'd5, 8'd4};
        qb = '{8'd7};
        send_frame(qa, 8'd43, qb, 10, 10);
        checks++; if (a_o !== 32'h0000_0504) begin failures++; $display("FAIL basic_A: got %h expected 00000504", a_o); end
        checks++; if (opcode !== 6'd43) begin failures++; $display("FAIL basic_op: got %0d expected 43", opcode); end
        run_tx(1'b0);
    endtask

    task automatic test_long_hold();
        send_frame(rand_field(3), rand_data(), rand_field(2), 20, 20);
        run_tx(1'b0);
    endtask

    task automatic test_overflow();
        bq_t qa, qb;
        logic [7:0] first;
        qa = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        qb = rand_field(2);
        send_frame(qa, rand_data(), qb, 1, 4);
        checks++; if (a_o !== 32'h0203_0405) begin failures++; $display("FAIL ovf_A: got %h expected 02030405", a_o); end
        run_tx(1'b0);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ovf_err_hold: got %b expected 1", err); end
        first = rand_data();
        tx_seen.delete();
        send_byte(first, 2);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL ovf_err_clear: got %b expected 0", err); end
        qa = '{first};
        qb = rand_field(1);
        send_byte(DL, 2);
        send_byte(8'd3, 2);
        send_byte(qb[0], 2);
        send_byte(DL, 2);
        exp_a = field_val(qa);
        exp_b = field_val(qb);
        checks++; if (a_o !== exp_a) begin failures++; $display("FAIL ovf_next_A: got %h expected %h", a_o, exp_a); end
        run_tx(1'b0);
    endtask

    task automatic test_empty();
        bq_t qe;
        send_frame(qe, 8'd43, qe, 1, 3);
        run_tx(1'b0);
    endtask

    task automatic test_inject();
        send_frame(rand_field(4), rand_data(), rand_field(3), 1, 3);
        run_tx(1'b1);
        send_frame(rand_field(2), rand_data(), rand_field(4), 1, 3);
        run_tx(1'b0);
    endtask

    task automatic test_reset_mid_tx();
        int waited;
        send_frame(rand_field(4), rand_data(), rand_field(4), 1, 2);
        for (int k = 0; k < 2; k++) begin
            waited = 0;
            while (tx_seen.size() <= k && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            checks++;
            if (tx_seen.size() <= k) begin
                failures++;
                $display("FAIL rst_tx_timeout: got %0d pulses expected %0d", tx_seen.size(), k + 1);
            end
            if (k == 0) begin
                @(negedge clk); tx_done = 1'b1;
                @(negedge clk); tx_done = 1'b0;
            end
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_out, tx_start, a_o, b_o, opcode, busy, err} !== '0) begin
            failures++;
            $display("FAIL midtx_reset: got d_out=%h tx=%b A=%h B=%h op=%h busy=%b err=%b expected all 0",
                     d_out, tx_start, a_o, b_o, opcode, busy, err);
        end
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (tx_seen.size() != 2) begin failures++; $display("FAIL midtx_no_tx: got %0d pulses expected 2", tx_seen.size()); end
        send_frame(rand_field(2), rand_data(), rand_field(3), 1, 3);
        run_tx(1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            send_frame(rand_field($urandom_range(0, 5)), 8'($urandom_range(0, 255)),
                       rand_field($urandom_range(0, 5)), 1, 4);
            run_tx(f[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long_hold();
        test_overflow();
        test_empty();
        test_inject();
        test_reset_mid_tx();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
